// File: rtl/lbuf_video_out_if.sv
// Linebuffer video output bus: RAM read port, PS line handshake and video timing outputs.
interface lbuf_video_out_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int WORD_WIDTH    = 32,
  parameter int PIXEL_WIDTH   = 8
);
  logic [WORD_WIDTH-1:0]    i_data;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic                     line_ack;
  logic                     underflow_clr;
  logic                     hsync;
  logic                     vsync;
  logic                     vde;
  logic [PIXEL_WIDTH-1:0]   o_data;
  logic                     req_line;
  logic [12:0]              req_idx;
  logic                     req_bank;
  logic                     req_frame;
  logic                     underflow;
  logic                     line_drop;

  modport master (
    input  i_data, line_ack, underflow_clr,
    output addr, hsync, vsync, vde, o_data,
           req_line, req_idx, req_bank, req_frame, underflow, line_drop
  );

  modport slave (
    output i_data, line_ack, underflow_clr,
    input  addr, hsync, vsync, vde, o_data,
           req_line, req_idx, req_bank, req_frame, underflow, line_drop
  );
endinterface

// File: rtl/lbuf_video_out.sv
// Video timing generator reading pixels from a PS-filled ping-pong linebuffer,
// prefetching one line ahead and blanking lines that were not delivered in time.
module lbuf_video_out #(
  parameter int ADDRESS_WIDTH  = 10,
  parameter int WORD_WIDTH     = 32,
  parameter int PIXEL_WIDTH    = 8,
  parameter int READ_LATENCY   = 1,
  parameter int DISPLAY_WIDTH  = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter bit HSYNC_POL      = 1'b0,
  parameter bit VSYNC_POL      = 1'b0
) (
  input logic             pclk,
  input logic             reset_n,
  lbuf_video_out_if.master bus
);

  localparam int PPW = WORD_WIDTH / PIXEL_WIDTH;
  localparam int KW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int AW1 = ADDRESS_WIDTH - 1;
  localparam int RL  = READ_LATENCY;

  localparam logic [12:0] H_TOT = 13'(DISPLAY_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH);
  localparam logic [12:0] H_DW  = 13'(DISPLAY_WIDTH);
  localparam logic [12:0] H_SB  = 13'(DISPLAY_WIDTH + H_FRONT_PORCH);
  localparam logic [12:0] H_SE  = 13'(DISPLAY_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [12:0] V_TOT = 13'(DISPLAY_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [12:0] V_DH  = 13'(DISPLAY_HEIGHT);
  localparam logic [12:0] V_SB  = 13'(DISPLAY_HEIGHT + V_FRONT_PORCH);
  localparam logic [12:0] V_SE  = 13'(DISPLAY_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam logic [12:0] PPW13 = 13'(PPW);

  function automatic logic [PIXEL_WIDTH-1:0] pix_sel(input logic [WORD_WIDTH-1:0] word,
                                                     input logic [KW-1:0]         k);
    logic [WORD_WIDTH-1:0] sh;
    sh = word << (int'(k) * PIXEL_WIDTH);
    return sh[WORD_WIDTH-1 -: PIXEL_WIDTH];
  endfunction

  logic [12:0]    h, v, nxt_v, pf_idx;
  logic           line_act, bank, vde_c, line_start, line_end, pf_hit, ok_now, hs_c, vs_c;
  logic [1:0]     ready, ready_nxt;
  logic           pending, pend_bank, line_ok;
  logic [AW1-1:0] wa;
  logic [KW-1:0]  sel_c;

  logic           vld_p0, en_p0, hs_p0, vs_p0;
  logic [KW-1:0]  sel_p0;
  logic [RL-1:0]  vld_p1, en_p1, hs_p1, vs_p1;
  logic [KW-1:0]  sel_p1 [RL];

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      h <= '0;
      v <= V_TOT - 13'd1;
    end else if (h == H_TOT - 13'd1) begin
      h <= '0;
      v <= (v == V_TOT - 13'd1) ? '0 : v + 13'd1;
    end else begin
      h <= h + 13'd1;
    end
  end

  always_comb begin
    nxt_v      = v + 13'd1;
    line_act   = (v < V_DH);
    bank       = v[0];
    vde_c      = (h < H_DW) && line_act;
    line_start = (h == '0) && line_act;
    line_end   = (h == H_DW - 13'd1) && line_act;
    pf_hit     = (h == '0) && ((nxt_v < V_DH) || (v == V_TOT - 13'd1));
    pf_idx     = (v == V_TOT - 13'd1) ? '0 : nxt_v;
    // The ready bit is read before any same-cycle ack lands, so a late ack cannot rescue a line.
    ok_now     = line_start ? ready[bank] : line_ok;
    hs_c       = ((h >= H_SB) && (h < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
    vs_c       = ((v >= V_SB) && (v < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
    wa         = AW1'(h / PPW13);
    sel_c      = KW'(h % PPW13);
    ready_nxt  = ready;
    if (bus.line_ack && pending) ready_nxt[pend_bank] = 1'b1;
    if (line_end)                ready_nxt[bank]      = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      ready         <= '0;
      pending       <= 1'b0;
      pend_bank     <= 1'b0;
      line_ok       <= 1'b0;
      bus.req_line  <= 1'b0;
      bus.req_idx   <= '0;
      bus.req_bank  <= 1'b0;
      bus.req_frame <= 1'b0;
      bus.underflow <= 1'b0;
      bus.line_drop <= 1'b0;
    end else begin
      ready <= ready_nxt;
      if (pf_hit) begin
        pending   <= 1'b1;
        pend_bank <= pf_idx[0];
      end else if (bus.line_ack) begin
        pending   <= 1'b0;
      end
      bus.req_line  <= pf_hit;
      bus.req_frame <= pf_hit && (pf_idx == '0);
      if (pf_hit) begin
        bus.req_idx  <= pf_idx;
        bus.req_bank <= pf_idx[0];
      end
      if (line_start) line_ok <= ready[bank];
      bus.line_drop <= line_start && !ready[bank];
      if (line_start && !ready[bank]) bus.underflow <= 1'b1;
      else if (bus.underflow_clr)     bus.underflow <= 1'b0;
    end
  end

  // p0: RAM address issue, timing flags captured alongside
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      bus.addr <= '0;
      vld_p0   <= 1'b0;
      en_p0    <= 1'b0;
      hs_p0    <= ~HSYNC_POL;
      vs_p0    <= ~VSYNC_POL;
    end else begin
      bus.addr <= vde_c ? {bank, wa} : '0;
      vld_p0   <= vde_c;
      en_p0    <= ok_now;
      hs_p0    <= hs_c;
      vs_p0    <= vs_c;
    end
  end

  always_ff @(posedge pclk) sel_p0 <= sel_c;

  // p1: delay line matching the RAM read latency
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      vld_p1 <= '0;
      en_p1  <= '0;
      hs_p1  <= {RL{~HSYNC_POL}};
      vs_p1  <= {RL{~VSYNC_POL}};
    end else begin
      vld_p1 <= RL'({vld_p1, vld_p0});
      en_p1  <= RL'({en_p1, en_p0});
      hs_p1  <= RL'({hs_p1, hs_p0});
      vs_p1  <= RL'({vs_p1, vs_p0});
    end
  end

  always_ff @(posedge pclk) begin
    sel_p1[0] <= sel_p0;
    for (int i = 1; i < RL; i++) sel_p1[i] <= sel_p1[i-1];
  end

  // p2: output register, pixel picked from the returned word
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      bus.vde    <= 1'b0;
      bus.hsync  <= ~HSYNC_POL;
      bus.vsync  <= ~VSYNC_POL;
      bus.o_data <= '0;
    end else begin
      bus.vde    <= vld_p1[RL-1];
      bus.hsync  <= hs_p1[RL-1];
      bus.vsync  <= vs_p1[RL-1];
      bus.o_data <= (vld_p1[RL-1] && en_p1[RL-1]) ? pix_sel(bus.i_data, sel_p1[RL-1]) : '0;
    end
  end

endmodule

// File: tb/tb_lbuf_video_out.sv
// Directed bench: small 8x4 raster, one 8-bit/latency-1 instance and one
// 16-bit/latency-2/active-high-sync instance, each with a PS responder and RAM model.
module tb_lbuf_video_out;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_a_n, rst_b_n;
  logic ps_ack_a, ps_ack_b, xack_a, uclr_a;
  logic [3:0] hold_a;
  int res_a [2];
  int res_b [2];
  int n_cmp, n_err, cyc, drops_a, hcnt;
  logic [31:0] w, e;

  lbuf_video_out_if #(.ADDRESS_WIDTH(4), .WORD_WIDTH(32), .PIXEL_WIDTH(8))  ifa ();
  lbuf_video_out_if #(.ADDRESS_WIDTH(4), .WORD_WIDTH(32), .PIXEL_WIDTH(16)) ifb ();

  lbuf_video_out #(
    .ADDRESS_WIDTH(4), .WORD_WIDTH(32), .PIXEL_WIDTH(8), .READ_LATENCY(1),
    .DISPLAY_WIDTH(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(2), .H_BACK_PORCH(2),
    .DISPLAY_HEIGHT(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_a (.pclk(pclk), .reset_n(rst_a_n), .bus(ifa.master));

  lbuf_video_out #(
    .ADDRESS_WIDTH(4), .WORD_WIDTH(32), .PIXEL_WIDTH(16), .READ_LATENCY(2),
    .DISPLAY_WIDTH(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(2), .H_BACK_PORCH(2),
    .DISPLAY_HEIGHT(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (.pclk(pclk), .reset_n(rst_b_n), .bus(ifb.master));

  // Linebuffer word: bytes {B0|bank, 40|line, 80|word, 5A}
  function automatic logic [31:0] pat32(input logic b, input int l, input int wd);
    return {(8'hB0 | {7'd0, b}), (8'h40 | 8'(l)), (8'h80 | 8'(wd)), 8'h5A};
  endfunction

  logic [31:0] ram_a_q, ram_b_q1, ram_b_q2;
  always @(posedge pclk) begin
    ram_a_q  <= pat32(ifa.addr[3], res_a[ifa.addr[3]], int'(ifa.addr[2:0]));
    ram_b_q1 <= pat32(ifb.addr[3], res_b[ifb.addr[3]], int'(ifb.addr[2:0]));
    ram_b_q2 <= ram_b_q1;
  end

  assign ifa.i_data        = ram_a_q;
  assign ifa.line_ack      = ps_ack_a | xack_a;
  assign ifa.underflow_clr = uclr_a;
  assign ifb.i_data        = ram_b_q2;
  assign ifb.line_ack      = ps_ack_b;
  assign ifb.underflow_clr = 1'b0;

  always @(negedge pclk) if (ifa.line_drop) drops_a++;

  // PS for instance A: fills the requested line and acks 4 cycles later unless held
  initial begin : ps_a
    logic [12:0] idx;
    ps_ack_a = 1'b0;
    res_a[0] = 0;
    res_a[1] = 0;
    forever begin
      @(posedge pclk); #1;
      if (ifa.req_line && !hold_a[ifa.req_idx[1:0]]) begin
        idx = ifa.req_idx;
        repeat (4) begin @(posedge pclk); #1; end
        res_a[idx[0]] = int'(idx);
        ps_ack_a = 1'b1;
        @(posedge pclk); #1;
        ps_ack_a = 1'b0;
      end
    end
  end

  initial begin : ps_b
    logic [12:0] idx;
    ps_ack_b = 1'b0;
    res_b[0] = 0;
    res_b[1] = 0;
    forever begin
      @(posedge pclk); #1;
      if (ifb.req_line) begin
        idx = ifb.req_idx;
        repeat (3) begin @(posedge pclk); #1; end
        res_b[idx[0]] = int'(idx);
        ps_ack_b = 1'b1;
        @(posedge pclk); #1;
        ps_ack_b = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge pclk); #1;
      cyc++;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; drops_a = 0; hcnt = 0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    xack_a = 1'b0; uclr_a = 1'b0; hold_a = 4'b0000;
    repeat (3) begin @(posedge pclk); #1; end
    chk("rst_vde",  ifa.vde, 0);
    chk("rst_hs",   ifa.hsync, 1);
    chk("rst_vs",   ifa.vsync, 1);
    chk("rst_dat",  ifa.o_data, 0);
    chk("rst_req",  ifa.req_line, 0);
    chk("rst_uf",   ifa.underflow, 0);
    chk("rst_addr", ifa.addr, 0);
    chk("rst_b_hs", ifb.hsync, 0);
    chk("rst_b_vs", ifb.vsync, 0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    cyc = 0;

    // first prefetch straight out of reset
    goto(1);
    chk("req0_line",  ifa.req_line, 1);
    chk("req0_frame", ifa.req_frame, 1);
    chk("req0_idx",   ifa.req_idx, 0);
    chk("req0_bank",  ifa.req_bank, 0);
    goto(2);
    chk("req0_pulse", ifa.req_line, 0);
    goto(15);
    chk("req1_line",  ifa.req_line, 1);
    chk("req1_idx",   ifa.req_idx, 1);
    chk("req1_bank",  ifa.req_bank, 1);
    chk("req1_frame", ifa.req_frame, 0);

    // line 0: address ramp, pixel order, sync timing on both instances
    for (int n = 15; n <= 30; n++) begin
      goto(n);
      if (n <= 22) chk("a_addr", ifa.addr, (n - 15) / 4);
      if (n == 29) chk("a_addr_b1", ifa.addr, 8);
      if (n >= 16 && n <= 25) begin
        e = 0;
        if (n >= 17 && n <= 24) begin
          w = pat32(1'b0, 0, (n - 17) / 4);
          e = (w >> (8 * (3 - (n - 17) % 4))) & 32'hFF;
        end
        chk("a_vde", ifa.vde, (n >= 17 && n <= 24) ? 1 : 0);
        chk("a_dat", ifa.o_data, e);
      end
      if (n >= 17 && n <= 26) begin
        e = 0;
        if (n >= 18 && n <= 25) begin
          w = pat32(1'b0, 0, (n - 18) / 2);
          e = (w >> (16 * (1 - (n - 18) % 2))) & 32'hFFFF;
        end
        chk("b_vde", ifb.vde, (n >= 18 && n <= 25) ? 1 : 0);
        chk("b_dat", ifb.o_data, e);
      end
      if (n >= 26 && n <= 29) chk("a_hs", ifa.hsync, (n == 27 || n == 28) ? 0 : 1);
      if (n >= 27 && n <= 30) chk("b_hs", ifb.hsync, (n == 28 || n == 29) ? 1 : 0);
    end

    // line 1 comes from bank 1
    for (int n = 31; n <= 44; n++) begin
      goto(n);
      if (ifa.hsync == 1'b0) hcnt++;
      if (n == 31) chk("a_l1_b3", ifa.o_data, 32'hB1);
      if (n == 32) chk("a_l1_b2", ifa.o_data, 32'h41);
    end
    chk("a_hs_cnt", hcnt, 2);

    goto(86);  chk("a_vs_pre", ifa.vsync, 1);
    goto(87);  chk("a_vs_on",  ifa.vsync, 0); chk("b_vs_pre", ifb.vsync, 0);
    goto(88);  chk("b_vs_on",  ifb.vsync, 1);
    goto(100); chk("a_vs_end", ifa.vsync, 0);
    goto(101); chk("a_vs_off", ifa.vsync, 1);

    // two clean frames, then withhold line 2 of the third frame
    goto(200);
    chk("clean_uf",    ifa.underflow, 0);
    chk("clean_drops", drops_a, 0);
    hold_a = 4'b0100;
    goto(230); hold_a = 4'b0000;
    goto(238); chk("drop_pre",   ifa.line_drop, 0);
    goto(239); chk("drop_pulse", ifa.line_drop, 1); chk("uf_set", ifa.underflow, 1);
    goto(240); chk("drop_post",  ifa.line_drop, 0);
    for (int n = 241; n <= 248; n++) begin
      goto(n);
      chk("drop_vde", ifa.vde, 1);
      chk("drop_dat", ifa.o_data, 0);
    end
    goto(255); chk("l3_b3", ifa.o_data, 32'hB1);
    goto(256); chk("l3_b2", ifa.o_data, 32'h43);
    goto(260); chk("uf_sticky", ifa.underflow, 1);
    goto(262); uclr_a = 1'b1;
    goto(263); uclr_a = 1'b0;
    chk("uf_clr", ifa.underflow, 0);

    // acks with nothing pending during blanking, then starve lines 0 and 1
    goto(365); xack_a = 1'b1;
    goto(367); xack_a = 1'b0;
    goto(380); hold_a = 4'b0011;
    goto(407); chk("f4_l0_drop", ifa.line_drop, 1);
    goto(410); hold_a = 4'b0000;
    goto(421); chk("f4_l1_drop", ifa.line_drop, 1);
    for (int n = 423; n <= 430; n++) begin
      goto(n);
      chk("f4_l1_vde", ifa.vde, 1);
      chk("f4_l1_dat", ifa.o_data, 0);
    end

    // one-cycle reset in the middle of line 2
    goto(537);
    chk("mid_vde", ifa.vde, 1);
    chk("mid_uf",  ifa.underflow, 1);
    rst_a_n = 1'b0;
    goto(538);
    chk("mr_vde",  ifa.vde, 0);
    chk("mr_dat",  ifa.o_data, 0);
    chk("mr_addr", ifa.addr, 0);
    chk("mr_hs",   ifa.hsync, 1);
    chk("mr_uf",   ifa.underflow, 0);
    chk("mr_req",  ifa.req_line, 0);
    rst_a_n = 1'b1;
    goto(539);
    chk("mr_req0",   ifa.req_line, 1);
    chk("mr_frame0", ifa.req_frame, 1);
    chk("mr_idx0",   ifa.req_idx, 0);
    goto(555); chk("mr_l0_b3", ifa.o_data, 32'hB0);
    goto(556); chk("mr_l0_b2", ifa.o_data, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbuf_video_out.md
Name: lbuf_video_out

Overview:
- Parametrised video timing generator and ping-pong linebuffer reader. Supersedes the single-bank 8-bit RAW output controller.
- Generates hsync/vsync/vde and pixel data from a two-bank linebuffer filled by the Processing System (PS).
- Requests each line one line ahead with a req/ack handshake, and flags underflow when the PS fails to deliver in time.
- Configurable pixel width, pixels per word, sync polarity and RAM read latency.

Parameters:
ADDRESS_WIDTH, 10, linebuffer word address width; MSB is the bank select
WORD_WIDTH, 32, linebuffer word width
PIXEL_WIDTH, 8, bits per pixel; must divide WORD_WIDTH; PPW = WORD_WIDTH/PIXEL_WIDTH
READ_LATENCY, 1, cycles from addr to valid i_data (1 or 2)
DISPLAY_WIDTH / H_FRONT_PORCH / H_SYNC_PULSE / H_BACK_PORCH, 640/16/96/48, horizontal timing in pixels
DISPLAY_HEIGHT / V_FRONT_PORCH / V_SYNC_PULSE / V_BACK_PORCH, 480/10/2/33, vertical timing in lines
HSYNC_POL, 0, active level of hsync
VSYNC_POL, 0, active level of vsync

Ports:
pclk  in  1  pixel clock
reset_n  in  1  reset: synchronous, active-low, sampled on pclk
i_data  in  WORD_WIDTH  linebuffer read data
addr  out  ADDRESS_WIDTH  linebuffer read address
line_ack  in  1  single-cycle pulse from PS: requested line fully written
underflow_clr  in  1  clears the sticky underflow flag
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
vde  out  1  video data enable
o_data  out  PIXEL_WIDTH  pixel value
req_line  out  1  single-cycle pulse: request line req_idx into bank req_bank
req_idx  out  13  line index being requested
req_bank  out  1  destination bank (= req_idx[0])
req_frame  out  1  single-cycle pulse coincident with the request for line 0
underflow  out  1  sticky: some active line was not ready
line_drop  out  1  single-cycle pulse per dropped line

Behaviour:
- Timing constants: H_TOTAL = sum of the horizontal parameters; V_TOTAL = sum of the vertical parameters.
- Counters: h (0..H_TOTAL-1) and v (0..V_TOTAL-1), both 13-bit. h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
- Reset state: h=0, v=V_TOTAL-1, so the line-0 prefetch issues immediately.
- Other reset values: ready[1:0]=0, pending=0, underflow=0, line_drop=0, req_*=0, addr=0, vde=0, o_data=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- Reset asserted mid-frame aborts all state, including any outstanding request. A line_ack during reset is ignored.
- Prefetch: when h==0, the next displayed line is L = v+1 if v+1<DISPLAY_HEIGHT, or L = 0 if v==V_TOTAL-1. In those cases:
  - next cycle: req_line=1, req_idx=L, req_bank=L[0], pending=1, pend_bank=L[0];
  - req_frame=1 additionally when L==0.
- No request is issued on other lines.
- line_ack when pending=1: ready[pend_bank]<=1, pending<=0. line_ack when pending=0: ignored.
- Line start (h==0 and v<DISPLAY_HEIGHT), with bank b=v[0]: line_ok <= ready[b].
  - If !ready[b]: line_drop pulses, underflow<=1, and the whole line outputs o_data=0 (vde still asserts).
  - line_ack arriving on the same cycle as line start does not rescue the line.
- Line end (h==DISPLAY_WIDTH-1 on an active line): ready[b]<=0.
- If a line_ack and a line-end clear hit the same bank in the same cycle, the clear wins.
- underflow_clr clears underflow. If set and clear coincide, set wins.
- addr (registered):
  - active pixel: {b, h/PPW} zero-extended in the low ADDRESS_WIDTH-1 bits;
  - otherwise: 0.
- Pixel select: pixel k=h%PPW is i_data[WORD_WIDTH-1-k*PIXEL_WIDTH -: PIXEL_WIDTH] (MSB-first).
- Pipeline: counters, addr register, RAM (READ_LATENCY), output register.
  - All outputs for counter position (h,v) appear LAT = READ_LATENCY+2 cycles after the counters hold (h,v).
  - The sync/vde/select pipeline is delay-matched, so hsync, vsync, vde and o_data are mutually aligned.
  - The req_* outputs are not delayed: they appear one cycle after the counter event.
- Output functions:
  - hsync = HSYNC_POL when DISPLAY_WIDTH+H_FRONT_PORCH <= h < DISPLAY_WIDTH+H_FRONT_PORCH+H_SYNC_PULSE.
  - vsync defined analogously on v.
  - vde = h<DISPLAY_WIDTH && v<DISPLAY_HEIGHT.
  - o_data = 0 whenever vde=0.

Test Plan:
Common configuration for all scenarios: WORD_WIDTH=32, PIXEL_WIDTH=8, READ_LATENCY=1, ADDRESS_WIDTH=4, DISPLAY_WIDTH=8, H_FRONT_PORCH=H_SYNC_PULSE=H_BACK_PORCH=2 (H_TOTAL=14), DISPLAY_HEIGHT=4, V_FRONT_PORCH=V_SYNC_PULSE=V_BACK_PORCH=1 (V_TOTAL=7). The RAM model returns word = {bank,line,word} pattern.
1. Release reset -> cycle 1: req_line=1, req_frame=1, req_idx=0, req_bank=0. Ack at cycle 5. At cycle 14+LAT: vde=1, o_data sequence equals bytes 3,2,1,0 of word 0, then word 1 of bank 0. addr ramps 0,0,0,0,1,1,1,1.
2. Ack every request within 10 cycles for 2 frames -> underflow stays 0. hsync low exactly 2 cycles per line at h=10..11 (+LAT). vsync low for one line at v=5. Alternating banks appear on addr[3].
3. Withhold the ack for line 2 -> line_drop pulses at the line-2 start; o_data=0 for 8 vde cycles; underflow=1 until an underflow_clr pulse. Line 3 displays normally if acked.
4. line_ack with no pending request, and a duplicate ack -> ready unchanged; no spurious data shown on an unready line.
5. Assert reset_n=0 mid-line at v=2, h=5 for 1 cycle -> all outputs take reset values next cycle, and the line-0 request is reissued one cycle after release.
6. Rebuild with HSYNC_POL=VSYNC_POL=1, PIXEL_WIDTH=16, READ_LATENCY=2 -> sync pulses are active-high, 2 pixels per word MSB-first, and output alignment shifts by one extra cycle.
